// File: rtl/uart_rx_engine_if.sv
// Register-file side of the UART receive engine: line control, FIFO pop, FIFO head and status.
// master = register file, slave = receive engine.
interface uart_rx_engine_if #(
  parameter int unsigned FIFO_DEPTH = 16
);
  logic [7:0]                  LCR;
  logic                        pop_rx_fifo;
  logic                        rx_idle;
  logic [10:0]                 rx_fifo_out;
  logic [$clog2(FIFO_DEPTH):0] rx_fifo_count;
  logic                        push_rx_fifo;
  logic                        rx_fifo_empty;
  logic                        rx_fifo_full;
  logic                        rx_overrun;
  logic                        parity_error;
  logic                        framing_error;
  logic                        break_error;

  modport master (
    output LCR, pop_rx_fifo,
    input  rx_idle, rx_fifo_out, rx_fifo_count, push_rx_fifo, rx_fifo_empty, rx_fifo_full,
    input  rx_overrun, parity_error, framing_error, break_error
  );

  modport slave (
    input  LCR, pop_rx_fifo,
    output rx_idle, rx_fifo_out, rx_fifo_count, push_rx_fifo, rx_fifo_empty, rx_fifo_full,
    output rx_overrun, parity_error, framing_error, break_error
  );
endinterface

// File: rtl/uart_rx_engine.sv
// 16550-style UART receiver: synchronises and oversamples RXD, deframes 5-8 bit characters with
// optional parity, and queues {BI, FE, PE, data} entries in a character FIFO.
module uart_rx_engine #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic            RXD,
  input  logic            enable,
  uart_rx_engine_if.slave bus
);
  localparam int unsigned CntW   = $clog2(OVERSAMPLE);
  localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = AddrW + 1;
  localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        data_q, data_d;
  logic [5:0]        lcr_q, lcr_d;
  logic              par_bit_q, par_bit_d;
  logic              pe_q, pe_d;
  logic              armed_q, armed_d;
  logic              push_q, push_d;
  logic [10:0]       entry_q, entry_d;
  logic              rx_meta_q, rxs;
  logic              exp_par, bi;

  logic [10:0]       mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]  wptr_q, rptr_q;
  logic [CountW-1:0] count_q;
  logic              empty, full, do_pop, do_push;
  logic              unused_lcr_hi;

  assign unused_lcr_hi = ^bus.LCR[7:6];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_meta_q <= 1'b1;
      rxs       <= 1'b1;
    end else begin
      rx_meta_q <= RXD;
      rxs       <= rx_meta_q;
    end
  end

  assign exp_par = lcr_q[5] ? ~lcr_q[4] : (lcr_q[4] ? ^data_q : ~^data_q);
  assign bi      = (data_q == 8'd0) && !rxs && (!par_bit_q || !lcr_q[3]);

  // armed_q marks that rxs has been seen high in IDLE, so a low rxs is a genuine falling edge
  // and a held break produces only one entry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    data_d    = data_q;
    lcr_d     = lcr_q;
    par_bit_d = par_bit_q;
    pe_d      = pe_q;
    armed_d   = armed_q;
    push_d    = 1'b0;
    entry_d   = entry_q;
    unique case (state_q)
      StIdle: begin
        if (rxs) begin
          armed_d = 1'b1;
        end else if (enable && armed_q) begin
          state_d   = StStart;
          cnt_d     = '0;
          lcr_d     = bus.LCR[5:0];
          armed_d   = 1'b0;
          par_bit_d = 1'b0;
          pe_d      = 1'b0;
        end
      end
      StStart: if (enable) begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          bit_d   = '0;
          data_d  = '0;
          state_d = rxs ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: if (enable) begin
        if (cnt_q == CntFull) begin
          cnt_d         = '0;
          data_d[bit_q] = rxs;
          if (bit_q == 3'd4 + {1'b0, lcr_q[1:0]}) begin
            state_d = lcr_q[3] ? StParity : StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParity: if (enable) begin
        if (cnt_q == CntFull) begin
          cnt_d     = '0;
          par_bit_d = rxs;
          pe_d      = rxs != exp_par;
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: if (enable) begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          push_d  = 1'b1;
          entry_d = {bi, !rxs, pe_q, data_q};
          armed_d = rxs;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      lcr_q     <= '0;
      par_bit_q <= 1'b0;
      pe_q      <= 1'b0;
      armed_q   <= 1'b1;
      push_q    <= 1'b0;
      entry_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      lcr_q     <= lcr_d;
      par_bit_q <= par_bit_d;
      pe_q      <= pe_d;
      armed_q   <= armed_d;
      push_q    <= push_d;
      entry_q   <= entry_d;
    end
  end

  assign empty   = count_q == '0;
  assign full    = count_q == CountW'(FIFO_DEPTH);
  assign do_pop  = bus.pop_rx_fifo && !empty;
  assign do_push = push_q && (!full || do_pop);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (do_push) mem_q[wptr_q] <= entry_q;
  end

  assign bus.rx_idle       = state_q == StIdle;
  assign bus.rx_fifo_out   = empty ? 11'd0 : mem_q[rptr_q];
  assign bus.rx_fifo_count = count_q;
  assign bus.push_rx_fifo  = push_q;
  assign bus.rx_fifo_empty = empty;
  assign bus.rx_fifo_full  = full;
  assign bus.rx_overrun    = push_q && full && !do_pop;
  assign bus.parity_error  = bus.rx_fifo_out[8] && !empty;
  assign bus.framing_error = bus.rx_fifo_out[9] && !empty;
  assign bus.break_error   = bus.rx_fifo_out[10] && !empty;
endmodule

// File: tb/tb_uart_rx_engine.sv
// Randomised bench for uart_rx_engine: serial frames are driven bit by bit and every popped
// entry is compared against a queue of entries predicted from the framing rules.
module tb_uart_rx_engine;
  localparam int unsigned Depth = 16;
  localparam int unsigned Os    = 16;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  logic RXD     = 1'b1;
  logic enable  = 1'b0;

  uart_rx_engine_if #(.FIFO_DEPTH(Depth)) bus ();

  uart_rx_engine #(.FIFO_DEPTH(Depth), .OVERSAMPLE(Os)) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .RXD    (RXD),
    .enable (enable),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;

  int total = 0, bad = 0;
  int push_cnt = 0, ovr_cnt = 0, exp_ovr = 0;
  int en_div = 1;
  logic [10:0] model_q[$];

  initial begin : en_gen
    int ec;
    ec = 0;
    forever begin
      @(negedge PCLK);
      ec = (ec + 1 >= en_div) ? 0 : ec + 1;
      enable = (ec == 0);
    end
  end

  always @(negedge PCLK) begin
    if (bus.push_rx_fifo === 1'b1) push_cnt++;
    if (bus.rx_overrun === 1'b1) ovr_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  function automatic int bitc();
    return Os * en_div;
  endfunction

  function automatic logic exp_parity(input logic [7:0] d, input logic [7:0] lcr);
    if (lcr[5]) return ~lcr[4];
    return lcr[4] ? ^d : ~^d;
  endfunction

  // Drives one frame and appends the predicted entry (or an expected overrun) to the model.
  task automatic send_frame(input logic [7:0] d, input logic [7:0] lcr, input bit bad_par,
                            input bit bad_stop);
    int len;
    logic [7:0] dm;
    logic p;
    logic [10:0] e;
    len = 5 + int'(lcr[1:0]);
    dm = d & 8'((1 << len) - 1);
    p = exp_parity(dm, lcr) ^ bad_par;
    bus.LCR = lcr;
    RXD = 1'b0;
    wait_cyc(bitc());
    bus.LCR = 8'($urandom);
    for (int i = 0; i < len; i++) begin
      RXD = dm[i];
      wait_cyc(bitc());
    end
    if (lcr[3]) begin
      RXD = p;
      wait_cyc(bitc());
    end
    RXD = !bad_stop;
    wait_cyc(bitc());
    RXD = 1'b1;
    if (bad_stop || lcr[2]) wait_cyc(bitc());
    wait_cyc(3);
    e = {bad_stop && dm == 8'd0 && (!lcr[3] || !p), bad_stop, lcr[3] && bad_par, dm};
    if (model_q.size() < Depth) model_q.push_back(e);
    else exp_ovr++;
  endtask

  task automatic pop_check(input string tag);
    logic [10:0] e;
    if (model_q.size() == 0) begin
      check_eq({tag, "_empty_out"}, 32'(bus.rx_fifo_out), 32'd0);
      check_eq({tag, "_empty_flag"}, 32'(bus.rx_fifo_empty), 32'd1);
    end else begin
      e = model_q.pop_front();
      check_eq({tag, "_head"}, 32'(bus.rx_fifo_out), 32'(e));
      check_eq({tag, "_pe"}, 32'(bus.parity_error), 32'(e[8]));
      check_eq({tag, "_fe"}, 32'(bus.framing_error), 32'(e[9]));
      check_eq({tag, "_bi"}, 32'(bus.break_error), 32'(e[10]));
    end
    bus.pop_rx_fifo = 1'b1;
    @(negedge PCLK);
    bus.pop_rx_fifo = 1'b0;
    @(negedge PCLK);
  endtask

  initial begin
    int p0, o0;
    bit seen;
    bus.LCR = 8'h03;
    bus.pop_rx_fifo = 1'b0;
    wait_cyc(3);
    check_eq("rst_idle", 32'(bus.rx_idle), 32'd1);
    check_eq("rst_count", 32'(bus.rx_fifo_count), 32'd0);
    check_eq("rst_out", 32'(bus.rx_fifo_out), 32'd0);
    check_eq("rst_push", 32'(bus.push_rx_fifo), 32'd0);
    PRESETn = 1'b1;
    wait_cyc(4);
    check_eq("rst_empty", 32'(bus.rx_fifo_empty), 32'd1);
    check_eq("rst_full", 32'(bus.rx_fifo_full), 32'd0);

    // 8N1 basic character
    p0 = push_cnt;
    send_frame(8'hA5, 8'h03, 1'b0, 1'b0);
    check_eq("t1_pushes", 32'(push_cnt - p0), 32'd1);
    check_eq("t1_count", 32'(bus.rx_fifo_count), 32'd1);
    check_eq("t1_out", 32'(bus.rx_fifo_out), 32'h0A5);
    pop_check("t1");

    // 7E1 with wrong then correct parity
    send_frame(8'h41, 8'h1A, 1'b1, 1'b0);
    check_eq("t2_out", 32'(bus.rx_fifo_out), 32'h141);
    pop_check("t2_bad");
    send_frame(8'h41, 8'h1A, 1'b0, 1'b0);
    pop_check("t2_good");

    // held break: a single FE+BI entry
    p0 = push_cnt;
    bus.LCR = 8'h03;
    RXD = 1'b0;
    wait_cyc(60 * bitc());
    check_eq("t3_pushes_low", 32'(push_cnt - p0), 32'd1);
    RXD = 1'b1;
    wait_cyc(2 * bitc());
    check_eq("t3_pushes_after", 32'(push_cnt - p0), 32'd1);
    model_q.push_back(11'h600);
    check_eq("t3_out", 32'(bus.rx_fifo_out), 32'h600);
    pop_check("t3");

    // fill past capacity
    o0 = ovr_cnt;
    exp_ovr = 0;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'($urandom), 8'h03, 1'b0, 1'b0);
      if (i == 15) begin
        check_eq("t4_count16", 32'(bus.rx_fifo_count), 32'd16);
        check_eq("t4_full", 32'(bus.rx_fifo_full), 32'd1);
      end
    end
    check_eq("t4_overrun", 32'(ovr_cnt - o0), 32'(exp_ovr));
    check_eq("t4_overrun_one", 32'(exp_ovr), 32'd1);
    check_eq("t4_head", 32'(bus.rx_fifo_out), 32'(model_q[0]));

    // pop in the same cycle as the push into a full FIFO
    o0 = ovr_cnt;
    exp_ovr = 0;
    seen = 1'b0;
    fork
      send_frame(8'h3C, 8'h03, 1'b0, 1'b0);
      begin
        for (int c = 0; c < 40 * Os && !seen; c++) begin
          @(negedge PCLK);
          if (bus.push_rx_fifo) begin
            seen = 1'b1;
            check_eq("t5_head_at_push", 32'(bus.rx_fifo_out), 32'(model_q[0]));
            bus.pop_rx_fifo = 1'b1;
            void'(model_q.pop_front());
            @(negedge PCLK);
            bus.pop_rx_fifo = 1'b0;
          end
        end
      end
    join
    check_eq("t5_push_seen", 32'(seen), 32'd1);
    check_eq("t5_count", 32'(bus.rx_fifo_count), 32'd16);
    check_eq("t5_overrun", 32'(ovr_cnt - o0), 32'd0);
    check_eq("t5_model_ovr", 32'(exp_ovr), 32'd0);
    while (model_q.size() > 0) pop_check("t5_drain");
    check_eq("t5_empty", 32'(bus.rx_fifo_empty), 32'd1);
    pop_check("t5_pop_empty");
    check_eq("t5_count0", 32'(bus.rx_fifo_count), 32'd0);

    // quarter-bit glitch on idle line
    p0 = push_cnt;
    RXD = 1'b0;
    wait_cyc(bitc() / 4);
    RXD = 1'b1;
    wait_cyc(2 * bitc());
    check_eq("t6_glitch_push", 32'(push_cnt - p0), 32'd0);
    check_eq("t6_glitch_idle", 32'(bus.rx_idle), 32'd1);

    // random frames, line settings, enable rates and pops
    o0 = ovr_cnt;
    exp_ovr = 0;
    for (int n = 0; n < 40; n++) begin
      en_div = int'($urandom_range(1, 3));
      send_frame(8'($urandom), {2'b00, 6'($urandom)}, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0));
      check_eq("rnd_count", 32'(bus.rx_fifo_count), 32'(model_q.size()));
      while (model_q.size() > int'($urandom_range(0, 5))) pop_check("rnd");
    end
    check_eq("rnd_overrun", 32'(ovr_cnt - o0), 32'(exp_ovr));
    while (model_q.size() > 0) pop_check("rnd_drain");

    // reset in the middle of DATA
    en_div = 1;
    send_frame(8'h5A, 8'h03, 1'b0, 1'b0);
    bus.LCR = 8'h03;
    RXD = 1'b0;
    wait_cyc(bitc());
    RXD = 1'b1;
    wait_cyc(3 * bitc());
    PRESETn = 1'b0;
    wait_cyc(2);
    check_eq("rstm_idle", 32'(bus.rx_idle), 32'd1);
    check_eq("rstm_count", 32'(bus.rx_fifo_count), 32'd0);
    check_eq("rstm_out", 32'(bus.rx_fifo_out), 32'd0);
    model_q.delete();
    p0 = push_cnt;
    PRESETn = 1'b1;
    wait_cyc(12 * bitc());
    check_eq("rstm_no_push", 32'(push_cnt - p0), 32'd0);
    check_eq("rstm_empty", 32'(bus.rx_fifo_empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
